sr_cmd_ctrl: RTL and testbench
==============================

# sr_cmd_ctrl

Upstream command stage for the set/reset flip-flop. It takes two raw, asynchronous, possibly bouncing request lines (set and clear) and synchronizes and debounces them. It turns each accepted rising edge into a single-cycle `s` or `r` pulse. Its outputs drive the flip-flop's `s`/`r` inputs directly, and it guarantees that `s` and `r` are never high together, so the flip-flop's s=r=1 (high-Z) case is never reached.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples needed to accept a level change; legal range 1..255.
- `HOLDOFF_CYCLES`, default 2: idle cycles forced after each pulse; legal range 0..255.
- `SET_PRIORITY`, default 1: 1 = set wins a conflict, 0 = clear wins.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `set_in`  in  1  raw set request, asynchronous to `clk`.
- `clr_in`  in  1  raw clear request, asynchronous to `clk`.
- `s`  out  1  one-cycle set pulse to the flip-flop.
- `r`  out  1  one-cycle reset pulse to the flip-flop.
- `busy`  out  1  high during ISSUE and HOLDOFF.
- `conflict`  out  1  one-cycle pulse when set and clear events compete and one is dropped.

## Operation
- Synchronizer: two flops per input; both reset to 0.
- Debounce, per channel:
  - Holds a debounced level (reset 0) and a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - When the synchronized sample differs from the debounced level, the counter increments.
  - When the sample equals the debounced level, the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- Event: a debounced 0→1 transition. Falling edges are ignored.
- FSM states: IDLE, ISSUE, HOLDOFF.
  - IDLE, single event → ISSUE, with the matching output registered high.
  - IDLE, set and clear events in the same cycle → ISSUE with the priority channel; the other is dropped; `conflict` pulses in the same cycle as the pulse.
  - ISSUE lasts exactly one cycle. Exit to HOLDOFF if HOLDOFF_CYCLES>0.
  - If HOLDOFF_CYCLES=0, ISSUE exits directly to the pending-resolution step below.
  - HOLDOFF counts HOLDOFF_CYCLES cycles, then resolves pending requests.
- Pending requests:
  - Each channel has one pending flag; events during ISSUE/HOLDOFF set it. Repeated events on the same channel merge.
  - On resolution, one pending flag → ISSUE for that channel next cycle, flag cleared.
  - Both flags pending → issue the priority channel, clear both flags, pulse `conflict`.
  - No flags pending → IDLE.
- `s` & `r` are never both 1 in any cycle. This is a hard invariant.

## Timing
- Reset values: `s`=0, `r`=0, `busy`=0, `conflict`=0, FSM=IDLE, all counters, pending flags, sync flops and debounced levels 0.
- Latency: edge 0 is the first edge that samples raw high. After a clean input:
  - debounced level rises after edge DEBOUNCE_CYCLES+1;
  - the pulse is high between edges DEBOUNCE_CYCLES+2 and DEBOUNCE_CYCLES+3.
- `busy` rises with the pulse. It falls HOLDOFF_CYCLES+1 cycles later if nothing is pending.
- Minimum pulse spacing is HOLDOFF_CYCLES+1 cycles, start to start.
- All outputs are registered; there are no combinational paths from inputs.
- Reset mid-operation:
  - Outputs are cleared asynchronously and pending requests are lost.
  - An input held high through reset release yields one pulse DEBOUNCE_CYCLES+2 edges after release.
- Bounce shorter than DEBOUNCE_CYCLES synchronized samples produces no event.

## Structure
- Package `sr_ctrl_pkg`: FSM state enum (IDLE, ISSUE, HOLDOFF) and the counter-width function/constant.
- Sub-module `sr_debounce`: synchronizer, debounce and rise-event logic for one channel. It is instantiated twice.
- The FSM, pending flags and output registers live in `sr_cmd_ctrl`.

## Test plan
All scenarios use the defaults D=4, H=2, SET_PRIORITY=1.
- Clean set: `set_in` held high from edge 0 → `s`=1 for exactly the cycle after edge 6; `busy`=1 for 3 cycles; `r`=0 throughout.
- Bounce rejection: `set_in` toggles high 3 cycles, low 1, repeatedly → no `s` pulse. Then held high 4+ samples → one `s` pulse.
- Simultaneous: `set_in` and `clr_in` rise on the same edge → one `s` pulse with `conflict`=1 in the same cycle; no `r`. Repeat with SET_PRIORITY=0 → `r` only.
- Pending during holdoff: a clear event arrives 1 cycle after the `s` pulse → `r` pulses exactly 3 cycles after `s`. `busy` stays high continuously.
- Reset mid-holdoff: assert `rst` with a clear pending → outputs 0 immediately and no `r` after release. With `set_in` held high across release → `s` at edge 6 after release.
- Invariant: random bouncing stimulus on both inputs for 10k cycles → `s`&`r` never both 1, and no two pulses closer than 3 cycles apart.

Source files
------------

// File: rtl/sr_ctrl_pkg.sv
// Shared types and sizing helpers for the set/reset command stage.
package sr_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      HOLDOFF = 2'd2
   } state_t;

   // Width of a counter that must hold 0..n; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sr_debounce.sv
// One request channel: two-flop synchronizer, stability debounce, and a
// single-cycle registered pulse on each accepted debounced rising edge.
module sr_debounce
   import sr_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic rise
);

   localparam int W = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);

   logic         sync1;
   logic         sync2;
   logic         level;
   logic [W-1:0] cnt;

   // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
         rise  <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         rise  <= 1'b0;
         if (sync2 != level) begin
            if (cnt == LAST) begin
               level <= sync2;
               cnt   <= '0;
               rise  <= sync2;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/sr_cmd_ctrl.sv
// Command stage in front of the S/R flip-flop: turns debounced request edges
// into mutually exclusive one-cycle s/r pulses with a holdoff between them.
module sr_cmd_ctrl
   import sr_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int HOLDOFF_CYCLES  = 2,
   parameter int SET_PRIORITY    = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic set_in,
   input  logic clr_in,
   output logic s,
   output logic r,
   output logic busy,
   output logic conflict
);

   localparam int HW = cnt_width(HOLDOFF_CYCLES);
   localparam logic [HW-1:0] H_LAST = HW'((HOLDOFF_CYCLES == 0) ? 0 : HOLDOFF_CYCLES - 1);
   localparam logic SET_PRI = (SET_PRIORITY != 0);

   logic          set_ev;
   logic          clr_ev;
   state_t        state;
   logic [HW-1:0] hcnt;
   logic          pend_set;
   logic          pend_clr;
   logic          eff_set;
   logic          eff_clr;
   logic          pick_set;
   logic          pick_clr;
   logic          both;
   logic          resolve;

   sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (set_in),
      .rise (set_ev)
   );

   sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (clr_in),
      .rise (clr_ev)
   );

   // Pending flags are always clear in IDLE, so one arbiter serves both the
   // fresh-event case and the end-of-holdoff resolution.
   always_comb begin
      eff_set  = pend_set | set_ev;
      eff_clr  = pend_clr | clr_ev;
      both     = eff_set & eff_clr;
      pick_set = eff_set & (~eff_clr | SET_PRI);
      pick_clr = eff_clr & ~pick_set;
      resolve  = 1'b0;
      case (state)
         IDLE:    resolve = 1'b1;
         ISSUE:   resolve = (HOLDOFF_CYCLES == 0);
         HOLDOFF: resolve = (hcnt == H_LAST);
         default: resolve = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         hcnt     <= '0;
         pend_set <= 1'b0;
         pend_clr <= 1'b0;
         s        <= 1'b0;
         r        <= 1'b0;
         busy     <= 1'b0;
         conflict <= 1'b0;
      end else begin
         s        <= 1'b0;
         r        <= 1'b0;
         conflict <= 1'b0;
         if (resolve) begin
            pend_set <= 1'b0;
            pend_clr <= 1'b0;
            hcnt     <= '0;
            if (eff_set | eff_clr) begin
               state    <= ISSUE;
               s        <= pick_set;
               r        <= pick_clr;
               conflict <= both;
               busy     <= 1'b1;
            end else begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         end else begin
            state    <= HOLDOFF;
            busy     <= 1'b1;
            pend_set <= eff_set;
            pend_clr <= eff_clr;
            hcnt     <= (state == ISSUE) ? '0 : hcnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sr_cmd_ctrl.sv
// Directed bench for sr_cmd_ctrl: one instance with set priority, one with
// clear priority, both driven by the same request lines.
module tb_sr_cmd_ctrl;

   logic clk;
   logic rst;
   logic set_in;
   logic clr_in;
   logic s0, r0, busy0, conf0;
   logic s1, r1, busy1, conf1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int last0  = -1;
   int last1  = -1;
   int s_cnt0 = 0;
   int r_cnt0 = 0;
   int s_cnt1 = 0;
   int r_cnt1 = 0;

   sr_cmd_ctrl #(.DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(2), .SET_PRIORITY(1)) dut0 (
      .clk      (clk),
      .rst      (rst),
      .set_in   (set_in),
      .clr_in   (clr_in),
      .s        (s0),
      .r        (r0),
      .busy     (busy0),
      .conflict (conf0)
   );

   sr_cmd_ctrl #(.DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(2), .SET_PRIORITY(0)) dut1 (
      .clk      (clk),
      .rst      (rst),
      .set_in   (set_in),
      .clr_in   (clr_in),
      .s        (s1),
      .r        (r1),
      .busy     (busy1),
      .conflict (conf1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Invariant and pulse-spacing monitor on both instances.
   always @(negedge clk) begin
      if (rst) begin
         last0 = -1;
         last1 = -1;
      end else begin
         cyc++;
         check("s_and_r_0", int'(s0 & r0), 0);
         check("s_and_r_1", int'(s1 & r1), 0);
         if (s0 | r0) begin
            if (last0 >= 0) check("spacing_0", int'((cyc - last0) >= 3), 1);
            last0 = cyc;
         end
         if (s1 | r1) begin
            if (last1 >= 0) check("spacing_1", int'((cyc - last1) >= 3), 1);
            last1 = cyc;
         end
         s_cnt0 += int'(s0);
         r_cnt0 += int'(r0);
         s_cnt1 += int'(s1);
         r_cnt1 += int'(r1);
      end
   end

   initial begin
      int base_s;
      int base_r;
      rst    = 1'b1;
      set_in = 1'b0;
      clr_in = 1'b0;
      idle(3);
      check("rst_s",    int'(s0),    0);
      check("rst_r",    int'(r0),    0);
      check("rst_busy", int'(busy0), 0);
      check("rst_conf", int'(conf0), 0);
      rst = 1'b0;
      idle(4);

      // Clean set: pulse after edge 6, busy for edges 6..8.
      set_in = 1'b1;
      for (int k = 0; k < 11; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("clean_s_k%0d", k),    int'(s0),    int'(k == 6));
         check($sformatf("clean_busy_k%0d", k), int'(busy0), int'(k >= 6 && k <= 8));
         check($sformatf("clean_r_k%0d", k),    int'(r0),    0);
         check($sformatf("clean_conf_k%0d", k), int'(conf0), 0);
      end
      set_in = 1'b0;
      idle(12);

      // Bounce: 3 high / 1 low never survives four stable samples.
      base_s = s_cnt0;
      for (int rep = 0; rep < 6; rep++) begin
         for (int c = 0; c < 4; c++) begin
            set_in = (c < 3);
            idle(1);
         end
      end
      set_in = 1'b0;
      idle(10);
      check("bounce_no_pulse", s_cnt0, base_s);
      set_in = 1'b1;
      idle(12);
      check("bounce_then_hold", s_cnt0, base_s + 1);
      set_in = 1'b0;
      idle(12);

      // Simultaneous rise: set wins on dut0, clear wins on dut1.
      set_in = 1'b1;
      clr_in = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("sim_s0_k%0d", k), int'(s0),    int'(k == 6));
         check($sformatf("sim_r0_k%0d", k), int'(r0),    0);
         check($sformatf("sim_c0_k%0d", k), int'(conf0), int'(k == 6));
         check($sformatf("sim_s1_k%0d", k), int'(s1),    0);
         check($sformatf("sim_r1_k%0d", k), int'(r1),    int'(k == 6));
         check($sformatf("sim_c1_k%0d", k), int'(conf1), int'(k == 6));
      end
      set_in = 1'b0;
      clr_in = 1'b0;
      idle(12);

      // Clear event one cycle behind set: r three cycles after s, busy held.
      set_in = 1'b1;
      for (int k = 0; k < 14; k++) begin
         @(posedge clk);
         #1;
         if (k == 0) clr_in = 1'b1;
         check($sformatf("pend_s_k%0d", k),    int'(s0),    int'(k == 6));
         check($sformatf("pend_r_k%0d", k),    int'(r0),    int'(k == 9));
         check($sformatf("pend_busy_k%0d", k), int'(busy0), int'(k >= 6 && k <= 11));
         check($sformatf("pend_conf_k%0d", k), int'(conf0), 0);
         check($sformatf("pend_r1_k%0d", k),   int'(r1),    int'(k == 9));
      end
      set_in = 1'b0;
      clr_in = 1'b0;
      idle(12);

      // Reset while a clear is pending in holdoff; set stays high across it.
      set_in = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         if (k == 0) clr_in = 1'b1;
      end
      check("pre_rst_busy", int'(busy0), 1);
      rst    = 1'b1;
      clr_in = 1'b0;
      #1;
      check("mid_rst_s",    int'(s0),    0);
      check("mid_rst_r",    int'(r0),    0);
      check("mid_rst_busy", int'(busy0), 0);
      check("mid_rst_conf", int'(conf0), 0);
      idle(2);
      base_r = r_cnt0;
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("rel_s_k%0d", k), int'(s0), int'(k == 6));
         check($sformatf("rel_r_k%0d", k), int'(r0), 0);
      end
      set_in = 1'b0;
      idle(15);
      check("rel_no_r", r_cnt0, base_r);

      // Random slow toggling on both lines; the monitor guards the invariants.
      base_s = s_cnt0 + r_cnt0;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 5) == 0) set_in = ~set_in;
         if ($urandom_range(0, 5) == 0) clr_in = ~clr_in;
         idle(1);
      end
      set_in = 1'b0;
      clr_in = 1'b0;
      idle(20);
      check("random_saw_pulses", int'((s_cnt0 + r_cnt0) > base_s), 1);
      check("random_idle_busy",  int'(busy0), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
